sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Three-requester arbiter and refresh scheduler in front of the single-command SDRAM core inside the memory interface. It shares the core between three requesters: the display fetch path (DMEMADDR side), the capture write path (CMEMADDR/CMEMDOUT side) and the MCS IO bus bridge. It also owns the periodic auto-refresh timer, and it routes returning read data to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 21: word address width; 16-bit words.
- REF_INTERVAL, 780: cycles between refresh requests; 780 gives 15.6 us at 50 MHz.
- TAG_DEPTH, 4: maximum number of reads outstanding in the core; must be a power of two.
- AGE_LIMIT, 64: wait cycles before a port is promoted. Used only with the aging macro.

Ports (index 0 = display, 1 = capture, 2 = MCS):
- CLK  in  1  system clock. One clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  3  per-port request level.
- REQ_WE  in  3  per-port write (1) or read (0).
- REQ_ADDR  in  3*ADDR_W  packed addresses; port n occupies bits [n*ADDR_W +: ADDR_W].
- REQ_WDATA  in  48  packed write data, 16 bits per port.
- ACK  out  3  one-cycle pulse when the port's command is accepted by the core.
- RVALID  out  3  one-cycle pulse when read data for that port is valid.
- RDATA  out  16  read data, shared by all ports, qualified by RVALID.
- CMD_VALID  out  1  a command is presented to the core.
- CMD_READY  in  1  the core accepts the command.
- CMD_REF  out  1  the presented command is an auto-refresh.
- CMD_WE  out  1  write command.
- CMD_ADDR  out  ADDR_W  command address.
- CMD_WDATA  out  16  command write data.
- RD_VALID  in  1  core read data valid; returns are in issue order.
- RD_DATA  in  16  core read data.
- ERR  out  1  sticky error flag: RD_VALID arrived with no outstanding read tag.

## Operation
- The FSM has three states: ARB, ISSUE, REF_ISSUE.
- ARB selects a command in the following priority order:
  - A pending refresh goes to REF_ISSUE.
  - Otherwise REQ[0].
  - Otherwise round-robin between ports 1 and 2. The last-granted pointer toggles on each grant to port 1 or 2.
  - A read request is eligible only when the tag FIFO is not full. A write is always eligible.
  - The winner's REQ_WE, REQ_ADDR and REQ_WDATA are registered, and the FSM moves to ISSUE.
  - With no eligible request, the FSM stays in ARB.
- ISSUE:
  - CMD_VALID=1 with the registered fields.
  - On CMD_READY: ACK[winner] pulses; for a read, the winner id is pushed into the tag FIFO; the FSM returns to ARB.
- REF_ISSUE:
  - CMD_VALID=1 and CMD_REF=1; CMD_ADDR, CMD_WE and CMD_WDATA are 0.
  - On CMD_READY the pending-refresh count is decremented and the FSM returns to ARB.
- Refresh timer:
  - Down-counter reloaded with REF_INTERVAL-1 when it reaches 0. Reload happens on expiry, not on issue.
  - Each expiry increments the pending count, saturating at 2.
- Tag FIFO (TAG_DEPTH entries × 2 bits):
  - On RD_VALID the head entry is popped. RVALID[head] pulses and RDATA=RD_DATA, both registered, one cycle after RD_VALID.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - RD_VALID with an empty FIFO: ERR is set, no RVALID pulses, the FIFO is unchanged.
- Requesters must hold REQ and their fields stable until ACK. A request dropped before ACK may still be issued, because it was already registered in ARB.

## Timing
- Reset (synchronous) takes effect on the first rising edge with RST=1. At that edge:
  - All outputs go to 0, including ERR.
  - The FSM goes to ARB.
  - The tag FIFO is flushed.
  - The pending-refresh count is cleared and the timer is reloaded.
  - The round-robin pointer is set to favour port 1.
  - A command in flight at reset is abandoned with no ACK.
- Request to command: REQ sampled in ARB at cycle t gives CMD_VALID at t+1. With CMD_READY=1, ACK is at t+1 and the next ARB is at t+2.
- Sustained throughput is one command per 2 cycles.
- First refresh: after RST deasserts, the first expiry occurs REF_INTERVAL cycles later. CMD_REF is presented in the first ARB cycle that follows.
- CMD_VALID and all CMD fields are held stable while CMD_READY=0.
- Pending refresh and REQ[0] in the same ARB cycle: refresh wins.

## Configuration
- SDRAM_ARB_AGING_EN defined:
  - A per-port wait counter runs for ports 1 and 2 while REQ is high and the port is not granted. It clears on ACK or when REQ is low.
  - When a counter reaches AGE_LIMIT, that port ranks above port 0, but still below refresh.
  - If both ports 1 and 2 are aged, the round-robin pointer decides.
- Not defined: strict priority as described under Operation. Port 0 can starve ports 1 and 2 indefinitely.

## Test plan
- Refresh: REF_INTERVAL=16, all REQ=0, CMD_READY=1 → CMD_REF=1 with CMD_VALID 17 cycles after RST deasserts, then every 16 cycles.
- Priority: REQ=3'b101 held in the same cycle → ACK[0] first, ACK[2] two cycles later.
- Round-robin: REQ=3'b110 held continuously → ACK order 1, 2, 1, 2.
- Tag limit: port 2 issues 4 reads with RD_VALID held low → 5th read not ACKed. RD_VALID with RD_DATA=0x1234 → RVALID[2] pulses with RDATA=0x1234 one cycle later, then the 5th read is ACKed.
- Stray return: RD_VALID with the FIFO empty → ERR=1 and stays 1 until RST.
- Aging: macro defined, AGE_LIMIT=8, REQ[0] and REQ[2] held → ACK[2] within 11 cycles of its request. Macro undefined → ACK[2] never occurs.
- Reset mid-issue: RST pulsed while CMD_VALID=1 and CMD_READY=0 → CMD_VALID=0 next cycle, no ACK, tag FIFO empty.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter, auto-refresh scheduler and read-return router for the SDRAM core.
// Optional aging of ports 1/2 above port 0 is enabled with `define SDRAM_ARB_AGING_EN.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 21,
  parameter int REF_INTERVAL = 780,
  parameter int TAG_DEPTH    = 4,
  parameter int AGE_LIMIT    = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            REQ,
  input  logic [2:0]            REQ_WE,
  input  logic [3*ADDR_W-1:0]   REQ_ADDR,
  input  logic [47:0]           REQ_WDATA,
  output logic [2:0]            ACK,
  output logic [2:0]            RVALID,
  output logic [15:0]           RDATA,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic                  CMD_REF,
  output logic                  CMD_WE,
  output logic [ADDR_W-1:0]     CMD_ADDR,
  output logic [15:0]           CMD_WDATA,
  input  logic                  RD_VALID,
  input  logic [15:0]           RD_DATA,
  output logic                  ERR
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int REF_W = $clog2(REF_INTERVAL);

  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || AGE_LIMIT < 1) begin : g_param_check
    $error("sdram_port_arbiter: TAG_DEPTH must be a power of two >= 2 and AGE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {ARB, ISSUE, REF_ISSUE} state_t;

  state_t           state;
  logic [1:0]       win;
  logic             rr_last2;    // 1: port 2 was granted last, so port 1 is favoured next
  logic [1:0]       ref_pend;
  logic [REF_W-1:0] ref_timer;
  logic             ref_expire;
  logic             ref_done;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   tag_cnt;
  logic             tag_full;
  logic             tag_empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic [2:0]       elig;
  logic [2:1]       aged;
  logic             sel_valid;
  logic [1:0]       sel_port;
  logic [1:0]       tag_mem [TAG_DEPTH];

  assign accept     = (state == ISSUE) && CMD_READY;
  assign ACK        = accept ? (3'b001 << win) : 3'b000;
  assign push       = accept && !CMD_WE;
  assign pop        = RD_VALID && !tag_empty;
  assign tag_full   = (tag_cnt == (PTR_W+1)'(TAG_DEPTH));
  assign tag_empty  = (tag_cnt == '0);
  assign elig       = REQ & (REQ_WE | {3{!tag_full}});
  assign ref_expire = (ref_timer == '0);
  assign ref_done   = (state == REF_ISSUE) && CMD_READY;

`ifdef SDRAM_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age [1:2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      age[1] <= '0;
      age[2] <= '0;
    end else begin
      for (int i = 1; i <= 2; i++) begin
        if (!REQ[i] || ACK[i])
          age[i] <= '0;
        else if (age[i] != AGE_W'(AGE_LIMIT))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  assign aged[1] = elig[1] && (age[1] == AGE_W'(AGE_LIMIT));
  assign aged[2] = elig[2] && (age[2] == AGE_W'(AGE_LIMIT));
`else
  assign aged = 2'b00;
`endif

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = 2'd0;
    if (aged[1] && aged[2]) begin
      sel_valid = 1'b1;
      sel_port  = rr_last2 ? 2'd1 : 2'd2;
    end else if (aged[1]) begin
      sel_valid = 1'b1;
      sel_port  = 2'd1;
    end else if (aged[2]) begin
      sel_valid = 1'b1;
      sel_port  = 2'd2;
    end else if (elig[0]) begin
      sel_valid = 1'b1;
      sel_port  = 2'd0;
    end else if (elig[1] && elig[2]) begin
      sel_valid = 1'b1;
      sel_port  = rr_last2 ? 2'd1 : 2'd2;
    end else if (elig[1]) begin
      sel_valid = 1'b1;
      sel_port  = 2'd1;
    end else if (elig[2]) begin
      sel_valid = 1'b1;
      sel_port  = 2'd2;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ARB;
      win       <= 2'd0;
      rr_last2  <= 1'b1;
      CMD_VALID <= 1'b0;
      CMD_REF   <= 1'b0;
      CMD_WE    <= 1'b0;
      CMD_ADDR  <= '0;
      CMD_WDATA <= '0;
    end else begin
      case (state)
        ARB: begin
          if (ref_pend != 2'd0) begin
            state     <= REF_ISSUE;
            CMD_VALID <= 1'b1;
            CMD_REF   <= 1'b1;
            CMD_WE    <= 1'b0;
            CMD_ADDR  <= '0;
            CMD_WDATA <= '0;
          end else if (sel_valid) begin
            state     <= ISSUE;
            win       <= sel_port;
            CMD_VALID <= 1'b1;
            CMD_REF   <= 1'b0;
            CMD_WE    <= REQ_WE[sel_port];
            CMD_ADDR  <= REQ_ADDR[sel_port*ADDR_W +: ADDR_W];
            CMD_WDATA <= REQ_WDATA[sel_port*16 +: 16];
            if (sel_port != 2'd0)
              rr_last2 <= (sel_port == 2'd2);
          end
        end
        ISSUE, REF_ISSUE: begin
          if (CMD_READY) begin
            state     <= ARB;
            CMD_VALID <= 1'b0;
            CMD_REF   <= 1'b0;
          end
        end
        default: begin
          state     <= ARB;
          CMD_VALID <= 1'b0;
          CMD_REF   <= 1'b0;
        end
      endcase
    end
  end

  // Timer reloads on its own expiry, so refresh cadence does not drift with core back-pressure.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ref_timer <= REF_W'(REF_INTERVAL - 1);
      ref_pend  <= 2'd0;
    end else begin
      ref_timer <= ref_expire ? REF_W'(REF_INTERVAL - 1) : ref_timer - 1'b1;
      case ({ref_expire, ref_done})
        2'b10:   if (ref_pend != 2'd2) ref_pend <= ref_pend + 1'b1;
        2'b01:   ref_pend <= ref_pend - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: tag storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (push)
      tag_mem[wr_ptr] <= win;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      RVALID  <= 3'b000;
      RDATA   <= '0;
      ERR     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: ;
      endcase
      RVALID <= pop ? (3'b001 << tag_mem[rd_ptr]) : 3'b000;
      if (pop) RDATA <= RD_DATA;
      if (RD_VALID && tag_empty) ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: refresh cadence, priority, round-robin, tag limit,
// stray returns, aging (both builds of SDRAM_ARB_AGING_EN) and reset during an issue.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 21;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [2:0]          REQ = 3'b000;
  logic [2:0]          REQ_WE = 3'b000;
  logic [3*ADDR_W-1:0] REQ_ADDR;
  logic [47:0]         REQ_WDATA;
  logic [2:0]          ACK;
  logic [2:0]          RVALID;
  logic [15:0]         RDATA;
  logic                CMD_VALID;
  logic                CMD_READY = 1'b1;
  logic                CMD_REF;
  logic                CMD_WE;
  logic [ADDR_W-1:0]   CMD_ADDR;
  logic [15:0]         CMD_WDATA;
  logic                RD_VALID = 1'b0;
  logic [15:0]         RD_DATA = 16'h0000;
  logic                ERR;

  localparam logic [ADDR_W-1:0] A0 = 21'h000123;
  localparam logic [ADDR_W-1:0] A1 = 21'h0ABCDE;
  localparam logic [ADDR_W-1:0] A2 = 21'h1F0F0F;

  int checks   = 0;
  int failures = 0;
  int first_ack2;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .REF_INTERVAL(16), .TAG_DEPTH(4), .AGE_LIMIT(8)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .ACK(ACK), .RVALID(RVALID), .RDATA(RDATA),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_REF(CMD_REF), .CMD_WE(CMD_WE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    REQ      = 3'b000;
    RD_VALID = 1'b0;
    tick();
    RST = 1'b0;
    check("rst_cmd_valid", 32'(CMD_VALID), 32'd0);
    check("rst_cmd_ref",   32'(CMD_REF),   32'd0);
    check("rst_ack",       32'(ACK),       32'd0);
    check("rst_rvalid",    32'(RVALID),    32'd0);
    check("rst_err",       32'(ERR),       32'd0);
    check("rst_rdata",     32'(RDATA),     32'd0);
  endtask

  initial begin
    REQ_ADDR  = {A2, A1, A0};
    REQ_WDATA = {16'hC002, 16'hB001, 16'hA000};

    // Refresh cadence: idle requesters, core always ready.
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      tick();
      check("refresh_valid", 32'(CMD_VALID), (k == 17 || k == 33) ? 32'd1 : 32'd0);
      if (k == 17 || k == 33) begin
        check("refresh_ref",  32'(CMD_REF),  32'd1);
        check("refresh_addr", 32'(CMD_ADDR), 32'd0);
        check("refresh_we",   32'(CMD_WE),   32'd0);
      end
    end

    // Priority: port 0 beats port 2 when both raise in the same cycle.
    do_reset();
    REQ_WE = 3'b111;
    REQ    = 3'b101;
    tick();
    check("prio_ack0",   32'(ACK),       32'b001);
    check("prio_addr0",  32'(CMD_ADDR),  32'(A0));
    check("prio_wdata0", 32'(CMD_WDATA), 32'hA000);
    check("prio_we0",    32'(CMD_WE),    32'd1);
    REQ[0] = 1'b0;
    tick();
    check("prio_gap", 32'(ACK), 32'b000);
    tick();
    check("prio_ack2",  32'(ACK),      32'b100);
    check("prio_addr2", 32'(CMD_ADDR), 32'(A2));
    REQ = 3'b000;
    tick();

    // Round-robin between ports 1 and 2, starting with port 1.
    do_reset();
    REQ_WE = 3'b111;
    REQ    = 3'b110;
    tick();
    check("rr_ack_1a", 32'(ACK), 32'b010);
    check("rr_wdata1", 32'(CMD_WDATA), 32'hB001);
    tick();
    check("rr_gap", 32'(ACK), 32'b000);
    tick();
    check("rr_ack_2a", 32'(ACK), 32'b100);
    tick();
    tick();
    check("rr_ack_1b", 32'(ACK), 32'b010);
    tick();
    tick();
    check("rr_ack_2b", 32'(ACK), 32'b100);
    REQ = 3'b000;
    tick();

    // Tag limit: four reads fill the FIFO, the fifth waits for a return.
    do_reset();
    REQ_WE = 3'b000;
    REQ    = 3'b100;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("tag_read_ack", 32'(ACK), 32'b100);
      tick();
    end
    tick();
    check("tag_full_ack",   32'(ACK),       32'b000);
    check("tag_full_valid", 32'(CMD_VALID), 32'd0);
    tick();
    check("tag_full_valid2", 32'(CMD_VALID), 32'd0);
    RD_VALID = 1'b1;
    RD_DATA  = 16'h1234;
    tick();
    RD_VALID = 1'b0;
    check("tag_rvalid",      32'(RVALID),    32'b100);
    check("tag_rdata",       32'(RDATA),     32'h1234);
    check("tag_still_block", 32'(CMD_VALID), 32'd0);
    tick();
    check("tag_fifth_ack",  32'(ACK),    32'b100);
    check("tag_rvalid_end", 32'(RVALID), 32'b000);
    REQ = 3'b000;
    tick();

    // Stray return with nothing outstanding sets the sticky error.
    do_reset();
    RD_VALID = 1'b1;
    RD_DATA  = 16'hDEAD;
    tick();
    RD_VALID = 1'b0;
    check("stray_err",    32'(ERR),    32'd1);
    check("stray_rvalid", 32'(RVALID), 32'b000);
    repeat (4) tick();
    check("stray_err_sticky", 32'(ERR), 32'd1);

    // Aging: port 0 held continuously against port 2.
    do_reset();
    REQ_WE     = 3'b111;
    REQ        = 3'b101;
    first_ack2 = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ACK[2] && first_ack2 == 0) begin
        first_ack2 = k;
        REQ[2]     = 1'b0;
      end
    end
`ifdef SDRAM_ARB_AGING_EN
    check("aging_ack2_cycle", 32'(first_ack2), 32'd9);
`else
    check("no_aging_starved", 32'(first_ack2), 32'd0);
`endif
    REQ = 3'b000;
    tick();

    // Reset while a read command is stalled: no ACK, FIFO flushed.
    do_reset();
    REQ_WE    = 3'b000;
    REQ       = 3'b010;
    CMD_READY = 1'b1;
    tick();
    check("mid_first_ack", 32'(ACK), 32'b010);
    tick();
    CMD_READY = 1'b0;
    tick();
    check("mid_stall_valid", 32'(CMD_VALID), 32'd1);
    check("mid_stall_ack",   32'(ACK),       32'b000);
    check("mid_stall_addr",  32'(CMD_ADDR),  32'(A1));
    tick();
    check("mid_hold_valid", 32'(CMD_VALID), 32'd1);
    check("mid_hold_addr",  32'(CMD_ADDR),  32'(A1));
    check("mid_hold_we",    32'(CMD_WE),    32'd0);
    do_reset();
    CMD_READY = 1'b1;
    RD_VALID  = 1'b1;
    RD_DATA   = 16'h5555;
    tick();
    RD_VALID = 1'b0;
    check("mid_flush_err",    32'(ERR),    32'd1);
    check("mid_flush_rvalid", 32'(RVALID), 32'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
